// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory store buffer.
package dmem_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned OFFS_W    = 2;
  localparam int unsigned IDX_MAX_W = 32 - OFFS_W;

  // Store-buffer entry: the index field is wide enough for any array depth;
  // unused upper bits are held at zero.
  typedef struct packed {
    logic [IDX_MAX_W-1:0] index;
    logic [DATA_W-1:0]    data;
  } sb_entry_t;

  // Owner of the single array write port in a given cycle.
  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_LOAD,
    OWN_DRAIN
  } port_own_t;

endpackage

// File: rtl/dmem_array.sv
// Word RAM with one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] waddr_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic [$clog2(MEM_WORDS)-1:0] raddr_i,
  output logic [DATA_W-1:0]            rdata_o
);

  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  // Write port: one word per enabled rising edge.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_store_buffer.sv
// Data-memory responder: single-port word array fronted by an in-order
// store buffer. Define DMEM_SB_FWD_EN to forward youngest matching buffered
// data to loads; otherwise a matching load stalls while the buffer drains.
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned SB_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              stall,
  output logic              sb_empty
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned PTR_W = $clog2(SB_DEPTH);

  sb_entry_t          sb_q [SB_DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, slot;
  logic [PTR_W:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]   ld_idx;
  logic [DATA_W-1:0]  arr_rdata;
  logic               full, hit, enq, drain, arr_we;
  port_own_t          own;
`ifdef DMEM_SB_FWD_EN
  logic [DATA_W-1:0]  fwd_data;
`endif

  logic unused_addr;
  assign unused_addr = ^{addr[31:IDX_W+2], addr[1:0]};

  assign ld_idx   = addr[IDX_W+1:2];
  assign full     = (cnt_q == (PTR_W+1)'(SB_DEPTH));
  assign sb_empty = (cnt_q == '0);

  // Scan live entries oldest to youngest so the youngest match wins.
  always_comb begin
    hit  = 1'b0;
    slot = '0;
`ifdef DMEM_SB_FWD_EN
    fwd_data = '0;
`endif
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      slot = rptr_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < cnt_q) &&
          (sb_q[slot].index == IDX_MAX_W'(ld_idx))) begin
        hit = 1'b1;
`ifdef DMEM_SB_FWD_EN
        fwd_data = sb_q[slot].data;
`endif
      end
    end
  end

  // Stall: full buffer on a store; buffered match on a load without forwarding.
  always_comb begin
    stall = 1'b0;
    if (MemWrite) begin
      stall = full;
    end else if (MemRead) begin
`ifndef DMEM_SB_FWD_EN
      stall = hit;
`endif
    end
  end

  // Port arbitration and load data; a stalled load yields the port to the drain.
  always_comb begin
    own     = OWN_IDLE;
    rd_data = '0;
    if (MemRead && !MemWrite && !stall) begin
      own = OWN_LOAD;
    end else if (cnt_q != '0) begin
      own = OWN_DRAIN;
    end
    if (own == OWN_LOAD) begin
`ifdef DMEM_SB_FWD_EN
      rd_data = hit ? fwd_data : arr_rdata;
`else
      rd_data = arr_rdata;
`endif
    end
  end

  assign enq    = MemWrite && !full;
  assign drain  = (own == OWN_DRAIN);
  assign arr_we = drain && !rst;

  // Pointer and occupancy next-state.
  always_comb begin
    wptr_d = wptr_q + PTR_W'(enq);
    rptr_d = rptr_q + PTR_W'(drain);
    cnt_d  = cnt_q + (PTR_W+1)'(enq) - (PTR_W+1)'(drain);
  end

  // Buffer control registers; reset discards any pending stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry payload storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (enq) sb_q[wptr_q] <= '{index: IDX_MAX_W'(ld_idx), data: wr_data};
  end

  dmem_array #(
    .MEM_WORDS(MEM_WORDS)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .waddr_i (sb_q[rptr_q].index[IDX_W-1:0]),
    .wdata_i (sb_q[rptr_q].data),
    .raddr_i (ld_idx),
    .rdata_o (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomized self-checking bench for dmem_store_buffer with a queue-based
// reference model; honours DMEM_SB_FWD_EN the same way as the design.
module tb_dmem_store_buffer;

  localparam int unsigned MEM_WORDS = 256;
  localparam int unsigned SB_DEPTH  = 4;
  localparam int unsigned USED      = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWrite, MemRead;
  logic [31:0] addr, wr_data, rd_data;
  logic        stall, sb_empty;

  always #5 clk = ~clk;

  dmem_store_buffer #(
    .MEM_WORDS(MEM_WORDS),
    .SB_DEPTH (SB_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .stall    (stall),
    .sb_empty (sb_empty)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [31:0] mem_m [MEM_WORDS];
  logic [7:0]  qi [$];
  logic [31:0] qd [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One request cycle: drive, compare against the model, then advance the model.
  task automatic step(input logic we, input logic re, input logic [31:0] a,
                      input logic [31:0] d, output logic st_o,
                      output logic [31:0] rd_o, output logic se_o);
    logic        load_only, hit, exp_st, drn;
    logic [31:0] fwd, exp_rd;
    logic [7:0]  ix;
    @(negedge clk);
    MemWrite = we; MemRead = re; addr = a; wr_data = d;
    #1;
    ix = a[9:2];
    load_only = re && !we;
    hit = 1'b0;
    fwd = '0;
    foreach (qi[k]) if (qi[k] == ix) begin hit = 1'b1; fwd = qd[k]; end
    if (we) exp_st = (qi.size() == SB_DEPTH);
`ifdef DMEM_SB_FWD_EN
    else exp_st = 1'b0;
`else
    else if (re) exp_st = hit;
    else exp_st = 1'b0;
`endif
    exp_rd = '0;
    if (load_only && !exp_st) exp_rd = hit ? fwd : mem_m[ix];
    chk("stall", 32'(stall), 32'(exp_st));
    chk("sb_empty", 32'(sb_empty), 32'(qi.size() == 0));
    if (!(load_only && exp_st)) chk("rd_data", rd_data, exp_rd);
    st_o = stall; rd_o = rd_data; se_o = sb_empty;
    @(posedge clk);
    drn = (qi.size() > 0) && !(load_only && !exp_st);
    if (drn) begin
      mem_m[qi[0]] = qd[0];
      void'(qi.pop_front());
      void'(qd.pop_front());
    end
    if (we && !exp_st) begin
      qi.push_back(ix);
      qd.push_back(d);
    end
  endtask

  // Load with bounded retry while stalled, then pin the returned data.
  task automatic load_lit(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic st, se; logic [31:0] rd; int unsigned n;
    step(1'b0, 1'b1, a, '0, st, rd, se);
    n = 0;
    while (st && n < 2*SB_DEPTH) begin
      step(1'b0, 1'b1, a, '0, st, rd, se);
      n++;
    end
    chk({name, "_stall"}, 32'(st), 32'd0);
    chk(name, rd, exp);
  endtask

  initial begin
    logic st, se; logic [31:0] rd;
    logic we, re, prev_wst; logic [31:0] a, d;
    rst = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; addr = '0; wr_data = '0;
    @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_sb_empty", 32'(sb_empty), 32'd1);
    chk("rst_rd_data", rd_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int unsigned i = 0; i < USED; i++)
      step(1'b1, 1'b0, 32'(i * 4), 32'hA500_0000 | 32'(i), st, rd, se);
    step(1'b0, 1'b0, '0, '0, st, rd, se);
    step(1'b0, 1'b0, '0, '0, st, rd, se);
    chk("drained_empty", 32'(se), 32'd1);

    step(1'b0, 1'b1, 32'h10, '0, st, rd, se);
    chk("preload_rd", rd, 32'hA500_0004);
    chk("preload_stall", 32'(st), 32'd0);

    step(1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF, st, rd, se);
    step(1'b0, 1'b1, 32'h20, '0, st, rd, se);
`ifdef DMEM_SB_FWD_EN
    chk("fwd_stall", 32'(st), 32'd0);
    chk("fwd_rd", rd, 32'hDEAD_BEEF);
`else
    chk("match_stall", 32'(st), 32'd1);
    step(1'b0, 1'b1, 32'h20, '0, st, rd, se);
    chk("match_stall_once", 32'(st), 32'd0);
    chk("match_rd", rd, 32'hDEAD_BEEF);
`endif
    step(1'b0, 1'b0, '0, '0, st, rd, se);
    step(1'b0, 1'b0, '0, '0, st, rd, se);
    chk("idle_empty", 32'(se), 32'd1);
    load_lit("array_w8", 32'h20, 32'hDEAD_BEEF);

    step(1'b1, 1'b0, 32'h40, 32'h1, st, rd, se);
    step(1'b1, 1'b0, 32'h40, 32'h2, st, rd, se);
    load_lit("youngest", 32'h40, 32'h2);

    step(1'b1, 1'b1, 32'h30, 32'h55, st, rd, se);
    chk("both_rd", rd, 32'd0);
    load_lit("both_stored", 32'h30, 32'h55);

    step(1'b0, 1'b0, '0, '0, st, rd, se);
    step(1'b1, 1'b0, 32'h8, 32'h77, st, rd, se);
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b0; rst = 1'b1;
    #1;
    chk("rst_pending_empty", 32'(sb_empty), 32'd1);
    qi.delete(); qd.delete();
    @(negedge clk);
    rst = 1'b0;
    load_lit("rst_discard", 32'h8, 32'hA500_0002);

    we = 1'b0; re = 1'b0; a = '0; d = '0; st = 1'b0; prev_wst = 1'b0;
    for (int unsigned it = 0; it < 800; it++) begin
      if (!st) begin
        int unsigned op;
        op = $urandom_range(99);
        we = (op < 50);
        re = (op >= 40 && op < 85);
        a  = {$urandom_range(4194303), 6'(0)} | 32'($urandom_range(USED - 1) * 4)
             | 32'($urandom_range(3));
        a[9:6] = '0;
        d  = $urandom;
      end
      step(we, re, a, d, st, rd, se);
      if (we) begin
        chk("store_stall_run", 32'(prev_wst && st), 32'd0);
        prev_wst = st;
      end else begin
        prev_wst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
